// File: rtl/fnd_scan_cntr.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with per-frame value snapshot.
// Optional leading-zero suppression on digits 1..3 when FND_LEADING_ZERO_BLANK_EN is defined.
module fnd_scan_cntr #(
  parameter int SCAN_DIV = 100000,
  parameter int DIV_W    = 17
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        blank,
  output logic [7:0]  seg,
  output logic [3:0]  com,
  output logic        frame_tick
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic [15:0]      shadow;
  logic [3:0]       shadow_dp;

  logic             slot_end;
  logic             frame_end;
  logic [3:0]       nibble;
  logic [6:0]       hex_pat;
  logic             lz_dark;
  logic [7:0]       seg_nxt;
  logic [3:0]       com_nxt;

  assign slot_end  = (div == DIV_LAST);
  assign frame_end = slot_end && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (reset_p) begin
      div        <= '0;
      idx        <= 2'd0;
      shadow     <= 16'h0000;
      shadow_dp  <= 4'b0000;
      seg        <= 8'hFF;
      com        <= 4'b1111;
      frame_tick <= 1'b0;
    end else begin
      div        <= slot_end ? '0 : div + DIV_W'(1);
      if (slot_end) idx <= idx + 2'd1;
      // Snapshot lands on the same edge idx wraps, so a frame never mixes two values.
      if (frame_end) begin
        shadow    <= value;
        shadow_dp <= dp;
      end
      frame_tick <= frame_end;
      seg        <= seg_nxt;
      com        <= com_nxt;
    end
  end

  always_comb begin
    nibble = shadow[{idx, 2'b00} +: 4];
    case (nibble)
      4'h0:    hex_pat = 7'h40;
      4'h1:    hex_pat = 7'h79;
      4'h2:    hex_pat = 7'h24;
      4'h3:    hex_pat = 7'h30;
      4'h4:    hex_pat = 7'h19;
      4'h5:    hex_pat = 7'h12;
      4'h6:    hex_pat = 7'h02;
      4'h7:    hex_pat = 7'h78;
      4'h8:    hex_pat = 7'h00;
      4'h9:    hex_pat = 7'h10;
      4'hA:    hex_pat = 7'h08;
      4'hB:    hex_pat = 7'h03;
      4'hC:    hex_pat = 7'h46;
      4'hD:    hex_pat = 7'h21;
      4'hE:    hex_pat = 7'h06;
      default: hex_pat = 7'h0E;
    endcase
  end

`ifdef FND_LEADING_ZERO_BLANK_EN
  // Digit 0 is never suppressed so an all-zero value still shows a single "0".
  always_comb begin
    case (idx)
      2'd1:    lz_dark = (shadow[15:4]  == 12'h000);
      2'd2:    lz_dark = (shadow[15:8]  == 8'h00);
      2'd3:    lz_dark = (shadow[15:12] == 4'h0);
      default: lz_dark = 1'b0;
    endcase
  end
`else
  assign lz_dark = 1'b0;
`endif

  always_comb begin
    seg_nxt = 8'hFF;
    com_nxt = 4'b1111;
    if (!blank) begin
      com_nxt      = ~(4'b0001 << idx);
      seg_nxt[7]   = ~shadow_dp[idx];
      seg_nxt[6:0] = lz_dark ? 7'h7F : hex_pat;
    end
  end

endmodule

// File: tb/tb_fnd_scan_cntr.sv
// Directed bench for fnd_scan_cntr with SCAN_DIV=4; frame vectors plus reset, isolation, blank and mid-scan reset sequences.
module tb_fnd_scan_cntr;

  logic        clk = 1'b0;
  logic        reset_p;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        blank;
  logic [7:0]  seg;
  logic [3:0]  com;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fnd_scan_cntr #(.SCAN_DIV(4), .DIV_W(17)) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .value      (value),
    .dp         (dp),
    .blank      (blank),
    .seg        (seg),
    .com        (com),
    .frame_tick (frame_tick)
  );

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0][7:0] exp_seg;
  } vec_t;

  vec_t vecs [6];

`ifdef FND_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_tick(input string name);
    bit found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk(name, {7'd0, found}, 8'd1);
  endtask

  // Called on the negedge where frame_tick is seen; digit d is shown at negedge 2+4d.
  task automatic check_frame(input logic [3:0][7:0] es, input string tag);
    int cur = 0;
    for (int d = 0; d < 4; d++) begin
      repeat (2 + 4 * d - cur) @(negedge clk);
      cur = 2 + 4 * d;
      chk($sformatf("%s_com%0d", tag, d), {4'h0, com}, {4'h0, ~(4'b0001 << d)});
      chk($sformatf("%s_seg%0d", tag, d), seg, es[d]);
    end
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0100, {8'hF9, 8'h24, 8'hB0, 8'h99}};
    vecs[1] = '{16'hABCD, 4'b0000, {8'h88, 8'h83, 8'hC6, 8'hA1}};
    vecs[4] = '{16'h5F8E, 4'b1111, {8'h12, 8'h0E, 8'h00, 8'h06}};
    if (LZ) begin
      vecs[2] = '{16'h0050, 4'b0000, {8'hFF, 8'hFF, 8'h92, 8'hC0}};
      vecs[3] = '{16'h0000, 4'b1000, {8'h7F, 8'hFF, 8'hFF, 8'hC0}};
      vecs[5] = '{16'h0100, 4'b0001, {8'hFF, 8'hF9, 8'hC0, 8'h40}};
    end else begin
      vecs[2] = '{16'h0050, 4'b0000, {8'hC0, 8'hC0, 8'h92, 8'hC0}};
      vecs[3] = '{16'h0000, 4'b1000, {8'h40, 8'hC0, 8'hC0, 8'hC0}};
      vecs[5] = '{16'h0100, 4'b0001, {8'hC0, 8'hF9, 8'hC0, 8'h40}};
    end

    reset_p = 1'b1;
    value   = 16'h0000;
    dp      = 4'b0000;
    blank   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_com", {4'h0, com}, 8'h0F);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_tick", {7'd0, frame_tick}, 8'd0);
    reset_p = 1'b0;

    // First frame after release shows the reset shadow (0000)
    for (int n = 1; n <= 16; n++) begin
      int d;
      @(negedge clk);
      d = (n - 1) / 4;
      chk($sformatf("idle_com_n%0d", n), {4'h0, com}, {4'h0, ~(4'b0001 << d)});
      chk($sformatf("idle_seg_n%0d", n), seg, (LZ && d > 0) ? 8'hFF : 8'hC0);
      chk($sformatf("idle_tick_n%0d", n), {7'd0, frame_tick}, {7'd0, (n == 16)});
    end

    for (int i = 0; i < 6; i++) begin
      value = vecs[i].value;
      dp    = vecs[i].dp;
      wait_tick($sformatf("vec%0d_tick", i));
      check_frame(vecs[i].exp_seg, $sformatf("vec%0d", i));
    end

    // Snapshot isolation: change mid digit-1 slot
    value = 16'h1234;
    dp    = 4'b0000;
    wait_tick("iso_tick0");
    repeat (2) @(negedge clk);
    chk("iso_d0", seg, 8'h99);
    repeat (4) @(negedge clk);
    value = 16'hABCD;
    chk("iso_d1", seg, 8'hB0);
    repeat (4) @(negedge clk);
    chk("iso_d2", seg, 8'hA4);
    repeat (4) @(negedge clk);
    chk("iso_d3", seg, 8'hF9);
    wait_tick("iso_tick1");
    repeat (2) @(negedge clk);
    chk("iso_new_d0", seg, 8'hA1);
    repeat (4) @(negedge clk);
    chk("iso_new_d1", seg, 8'hC6);

    // Blank for 10 cycles starting at n=10; tick still due at n=16
    repeat (4) @(negedge clk);
    blank = 1'b1;
    for (int n = 11; n <= 20; n++) begin
      @(negedge clk);
      chk($sformatf("blk_com_n%0d", n), {4'h0, com}, 8'h0F);
      chk($sformatf("blk_seg_n%0d", n), seg, 8'hFF);
      chk($sformatf("blk_tick_n%0d", n), {7'd0, frame_tick}, {7'd0, (n == 16)});
    end
    blank = 1'b0;
    @(negedge clk);
    chk("blk_resume_com", {4'h0, com}, 8'h0D);
    chk("blk_resume_seg", seg, 8'hC6);

    // Reset during digit 2 (frame position n=10)
    repeat (5) @(negedge clk);
    chk("mid_pre_com", {4'h0, com}, 8'h0B);
    reset_p = 1'b1;
    @(negedge clk);
    chk("mid_rst_com", {4'h0, com}, 8'h0F);
    chk("mid_rst_seg", seg, 8'hFF);
    chk("mid_rst_tick", {7'd0, frame_tick}, 8'd0);
    reset_p = 1'b0;
    @(negedge clk);
    chk("mid_rel_com", {4'h0, com}, 8'h0E);
    chk("mid_rel_seg", seg, 8'hC0);
    repeat (14) @(negedge clk);
    chk("mid_tick15", {7'd0, frame_tick}, 8'd0);
    @(negedge clk);
    chk("mid_tick16", {7'd0, frame_tick}, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
